ntt_ctrl: RTL and testbench
===========================

Name: ntt_ctrl

Overview:
- Sequencer that drives the Kyber butterfly unit through a complete 256-point in-place transform.
  - Forward NTT uses CT butterflies.
  - Inverse NTT uses GS butterflies.
- Produces coefficient-RAM read/write addresses, twiddle-ROM addresses and the butterfly mode bit.
- Delays write addresses to match the memory plus butterfly pipeline, and inserts drain stalls at layer boundaries.
- Sits between the top-level command interface and the coefficient RAM / twiddle ROM / butterfly datapath.

Parameters:
- LOGN, 8, log2 of transform size (N=256).
- MEM_LAT, 1, RAM/ROM read latency in cycles.
- BF_LAT, 4, butterfly latency from A/B/W in to E/O out.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle request to begin a transform
- inv  in  1  0 = forward NTT (CT), 1 = inverse NTT (GS); sampled with start
- busy  out  1  transform in progress
- done  out  1  one-cycle pulse when the final write has been issued
- bf_ct  out  1  butterfly mode: 1 = CT, 0 = GS
- rd_en  out  1  read strobe for RAM ports a/b and twiddle ROM
- rd_addr_a  out  8  even-side coefficient address
- rd_addr_b  out  8  odd-side coefficient address
- tw_addr  out  7  twiddle ROM index
- wr_en  out  1  write strobe for E/O results
- wr_addr_a  out  8  write address for E
- wr_addr_b  out  8  write address for O

Behaviour:
- Reset: all outputs are 0, the FSM is in IDLE, and every valid bit in the write pipeline is cleared.
- PIPE = MEM_LAT + BF_LAT (default 5).
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: when start=1, latch inv and set bf_ct = ~inv. Clear layer l=0 and butterfly counter c=0, then go to RUN. busy=1 from the next cycle.
  - RUN: issue one butterfly per cycle (rd_en=1) and increment c. On c=127, go to DRAIN and load the drain counter with PIPE.
  - DRAIN: rd_en=0; decrement the drain counter. At zero:
    - if l=6, go to DONE;
    - otherwise l++, c=0, go to RUN.
  - DONE: done=1 and busy=0 for one cycle, then go to IDLE.
- start is ignored unless the FSM is in IDLE. inv is ignored outside the start cycle.
- Address generation, per layer l:
  - len = 128>>l (forward) or 2<<l (inverse).
  - Group g = c / len; offset j = c mod len.
  - rd_addr_a = g*2*len + j; rd_addr_b = rd_addr_a + len.
  - Forward: tw_addr = 128/len + g. Inverse: tw_addr = 256/len - 1 - g.
  - len is a power of two, so divide and modulo are shift/mask operations; no multipliers.
- Write pipeline:
  - {valid, rd_addr_a, rd_addr_b} enters a PIPE-deep shift register every cycle, with valid = rd_en.
  - Pipeline output drives wr_en, wr_addr_a and wr_addr_b.
  - A write occurs exactly PIPE cycles after its read.
- Hazard rule:
  - The last write of a layer lands in the final DRAIN cycle.
  - The first read of the next layer comes one cycle later, so there is no read-before-write across layers.
- Timing with start sampled at cycle 0:
  - Layer l issues in cycles 1+l*(128+PIPE) through 128+l*(128+PIPE).
  - done is asserted at cycle 1+7*(128+PIPE) (932 with defaults).
  - busy is high in cycles 1..931.
- Inverse scaling: the GS butterfly halves both outputs in every layer, giving the 1/128 factor over 7 layers. No separate scaling pass is performed.
- Reset mid-operation:
  - Immediately return to IDLE with all outputs 0.
  - In-flight writes are discarded (wr_en stays 0).
  - No done pulse is generated.
- No PWM/mult/add modes are issued; the butterfly's PWM control is tied 0 at top level.

Decomposition:
- Shared package holds:
  - constants N=256, LOGN=8, Q=3329, NLAYERS=7, BF_PER_LAYER=128;
  - the FSM state enum;
  - a twiddle-index function (layer, group, inv).
- Sub-module ntt_wr_pipe: parameterised-depth shift register of {valid, addr_a, addr_b} with async reset clearing the valid bits.

Test Plan:
- Forward, first 3 issues after start → (a,b,tw) = (0,128,1), (1,129,1), (2,130,1). First wr_en at cycle 6 with (0,128).
- Forward layer 1 boundary → rd_en low in cycles 129..133. First layer-1 issue at cycle 134 with (0,64,2). c=64 gives (128,192,3).
- Inverse, layer 0 → c=0 gives (0,2,127); c=1 gives (1,3,127); c=2 gives (4,6,126); c=127 gives (253,255,64). bf_ct=0.
- start pulsed at cycle 50 while busy → no effect. done still at cycle 932, and exactly 896 wr_en pulses in total.
- rst asserted at cycle 300 → all outputs 0 the same cycle. No wr_en or done afterwards. A new start at cycle 310 restarts from (0,128,1).
- End-to-end with butterfly, RAM and ROM models, random polynomial:
  - NTT output matches the golden Kyber reference.
  - NTT followed by INTT returns the original coefficients mod 3329.

Source files
------------

// File: rtl/ntt_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ntt_ctrl_pkg
// Shared definitions for the Kyber NTT sequencer:
//   - transform constants (N, LOGN, Q, NLAYERS, BF_PER_LAYER)
//   - sequencer FSM state encoding
//   - tw_index(): twiddle ROM index for a (layer, group, direction) triple
// ---------------------------------------------------------------------------
package ntt_ctrl_pkg;

    localparam int N            = 256;
    localparam int LOGN         = 8;
    localparam int Q            = 3329;
    localparam int NLAYERS      = 7;
    localparam int BF_PER_LAYER = 128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Forward walks the ROM upward from 128/len = 1<<layer; inverse walks it
    // downward from 256/len - 1 = (128>>layer) - 1, one entry per group.
    function automatic logic [6:0] tw_index(input logic [2:0] layer,
                                            input logic [6:0] group,
                                            input logic       inv);
        logic [7:0] base;
        logic [7:0] idx;
        if (inv) begin
            base = (8'd128 >> layer) - 8'd1;
            idx  = base - {1'b0, group};
        end else begin
            base = 8'd1 << layer;
            idx  = base + {1'b0, group};
        end
        return 7'(idx);
    endfunction

endpackage

// File: rtl/ntt_wr_pipe.sv
// ---------------------------------------------------------------------------
// ntt_wr_pipe
// Fixed-depth delay line carrying {valid, addr_a, addr_b} from the read side
// to the write side so each result is written exactly DEPTH cycles after
// its operands were read.
//   clk, rst              clock, asynchronous active-high reset (valid bits only)
//   in_vld/in_addr_a/b    read-side strobe and addresses, sampled every cycle
//   out_vld/out_addr_a/b  write-side strobe and addresses (addresses 0 when idle)
// ---------------------------------------------------------------------------
module ntt_wr_pipe #(
    parameter int DEPTH = 5,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_vld,
    input  logic [AW-1:0] in_addr_a,
    input  logic [AW-1:0] in_addr_b,
    output logic          out_vld,
    output logic [AW-1:0] out_addr_a,
    output logic [AW-1:0] out_addr_b
);

    logic [DEPTH-1:0] vld_q, vld_d;
    logic [AW-1:0]    addr_a_q [DEPTH];
    logic [AW-1:0]    addr_a_d [DEPTH];
    logic [AW-1:0]    addr_b_q [DEPTH];
    logic [AW-1:0]    addr_b_d [DEPTH];

    always_comb begin
        vld_d[0]    = in_vld;
        addr_a_d[0] = in_addr_a;
        addr_b_d[0] = in_addr_b;
        for (int i = 1; i < DEPTH; i++) begin
            vld_d[i]    = vld_q[i-1];
            addr_a_d[i] = addr_a_q[i-1];
            addr_b_d[i] = addr_b_q[i-1];
        end
    end

    // Only the valid bits need clearing; stale addresses are masked at the output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_a_q <= addr_a_d;
        addr_b_q <= addr_b_d;
    end

    assign out_vld    = vld_q[DEPTH-1];
    assign out_addr_a = vld_q[DEPTH-1] ? addr_a_q[DEPTH-1] : '0;
    assign out_addr_b = vld_q[DEPTH-1] ? addr_b_q[DEPTH-1] : '0;

endmodule

// File: rtl/ntt_ctrl.sv
// ---------------------------------------------------------------------------
// ntt_ctrl
// Sequencer for a 256-point in-place Kyber NTT (CT butterflies) or inverse
// NTT (GS butterflies, halving in every layer). Seven layers of 128
// butterflies, one per cycle, with a PIPE-cycle drain between layers so the
// last write of a layer lands before the first read of the next.
//   clk, rst               clock, asynchronous active-high reset
//   start, inv             one-cycle request; inv selects inverse (sampled with start)
//   busy, done             transform in progress / one-cycle completion pulse
//   bf_ct                  butterfly mode, 1 = CT, 0 = GS
//   rd_en, rd_addr_a/b     operand read strobe and coefficient addresses
//   tw_addr                twiddle ROM index
//   wr_en, wr_addr_a/b     result write strobe and addresses (E to a, O to b)
// ---------------------------------------------------------------------------
module ntt_ctrl
    import ntt_ctrl_pkg::*;
#(
    parameter int LOGN    = 8,
    parameter int MEM_LAT = 1,
    parameter int BF_LAT  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            inv,
    output logic            busy,
    output logic            done,
    output logic            bf_ct,
    output logic            rd_en,
    output logic [LOGN-1:0] rd_addr_a,
    output logic [LOGN-1:0] rd_addr_b,
    output logic [LOGN-2:0] tw_addr,
    output logic            wr_en,
    output logic [LOGN-1:0] wr_addr_a,
    output logic [LOGN-1:0] wr_addr_b
);

    localparam int PIPE = MEM_LAT + BF_LAT;
    localparam int DW   = $clog2(PIPE + 1);
    localparam int LW   = $clog2(LOGN);

    state_e          state_q, state_d;
    logic [LW-1:0]   layer_q, layer_d;
    logic [LOGN-2:0] cnt_q,   cnt_d;
    logic [DW-1:0]   drain_q, drain_d;
    logic            inv_q,   inv_d;
    logic            bf_ct_q, bf_ct_d;

    logic [LW-1:0]   sh;
    logic [LOGN-1:0] len;
    logic [LOGN-2:0] grp;
    logic [LOGN-1:0] offs;
    logic [LOGN-1:0] addr_a;
    logic [LOGN-1:0] addr_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            layer_q <= '0;
            cnt_q   <= '0;
            drain_q <= '0;
            inv_q   <= 1'b0;
            bf_ct_q <= 1'b0;
        end else begin
            state_q <= state_d;
            layer_q <= layer_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
            inv_q   <= inv_d;
            bf_ct_q <= bf_ct_d;
        end
    end

    always_comb begin
        state_d = state_q;
        layer_d = layer_q;
        cnt_d   = cnt_q;
        drain_d = drain_q;
        inv_d   = inv_q;
        bf_ct_d = bf_ct_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    inv_d   = inv;
                    bf_ct_d = ~inv;
                    layer_d = '0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q + (LOGN-1)'(1);
                if (&cnt_q) begin
                    // Counting PIPE-1 down to 0 gives exactly PIPE drain cycles.
                    drain_d = DW'(PIPE - 1);
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) begin
                    if (layer_q == LW'(NLAYERS - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        layer_d = layer_q + LW'(1);
                        cnt_d   = '0;
                        state_d = ST_RUN;
                    end
                end else begin
                    drain_d = drain_q - DW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // len = 1<<sh: forward halves the span each layer (128 down to 2),
    // inverse doubles it (2 up to 128). Group/offset are shift/mask of c.
    always_comb begin
        sh     = inv_q ? (layer_q + LW'(1)) : (LW'(LOGN - 1) - layer_q);
        len    = LOGN'(1) << sh;
        grp    = cnt_q >> sh;
        offs   = {1'b0, cnt_q} & (len - LOGN'(1));
        addr_a = ({1'b0, grp} << ({1'b0, sh} + (LW+1)'(1))) | offs;
        addr_b = addr_a | len;
    end

    assign rd_en     = (state_q == ST_RUN);
    assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done      = (state_q == ST_DONE);
    assign bf_ct     = bf_ct_q;
    assign rd_addr_a = rd_en ? addr_a : '0;
    assign rd_addr_b = rd_en ? addr_b : '0;
    assign tw_addr   = rd_en ? tw_index(layer_q, grp, inv_q) : '0;

    ntt_wr_pipe #(
        .DEPTH (PIPE),
        .AW    (LOGN)
    ) u_wr_pipe (
        .clk        (clk),
        .rst        (rst),
        .in_vld     (rd_en),
        .in_addr_a  (addr_a),
        .in_addr_b  (addr_b),
        .out_vld    (wr_en),
        .out_addr_a (wr_addr_a),
        .out_addr_b (wr_addr_b)
    );

endmodule

// File: tb/tb_ntt_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ntt_ctrl
// Directed bench for the NTT sequencer: a table of hand-computed per-cycle
// output vectors for forward, inverse and reset-interrupted runs, plus a
// behavioural RAM / twiddle ROM / butterfly model checked against a
// reference Kyber NTT and an NTT -> INTT round trip.
// ---------------------------------------------------------------------------
module tb_ntt_ctrl;
    import ntt_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst, start, inv;
    logic       busy, done, bf_ct, rd_en, wr_en;
    logic [7:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [6:0] tw_addr;

    ntt_ctrl #(.LOGN(8), .MEM_LAT(1), .BF_LAT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .inv       (inv),
        .busy      (busy),
        .done      (done),
        .bf_ct     (bf_ct),
        .rd_en     (rd_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .tw_addr   (tw_addr),
        .wr_en     (wr_en),
        .wr_addr_a (wr_addr_a),
        .wr_addr_b (wr_addr_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int run; int cyc;
        int rd;  int a;  int b;  int tw;
        int wr;  int wa; int wb;
        int bsy; int dn; int bf;
    } vec_t;

    typedef struct { int a; int b; int e; int o; } bf_t;

    vec_t vecs[$];
    bf_t  pend[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   wr_count = 0;
    int   done_count = 0;
    int   done_cyc = -1;
    int   e2e_err = 0;
    int   ram  [256];
    int   orig [256];
    int   gold [256];
    int   zetas[128];

    function automatic vec_t mk(input int r, cy, rd, a, b, tw, wr, wa, wb, bs, dn, bf);
        vec_t v;
        v.run = r;  v.cyc = cy;
        v.rd  = rd; v.a   = a;  v.b  = b;  v.tw = tw;
        v.wr  = wr; v.wa  = wa; v.wb = wb;
        v.bsy = bs; v.dn  = dn; v.bf = bf;
        return v;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int half(input int x);
        return (x % 2 == 0) ? x / 2 : (x + Q) / 2;
    endfunction

    // Memory + butterfly model: operands are read from the current array
    // before this cycle's write lands, results come back in issue order.
    task automatic model();
        bf_t p;
        int  a, b, w, t;
        if (rd_en) begin
            a   = ram[rd_addr_a];
            b   = ram[rd_addr_b];
            w   = zetas[tw_addr];
            p.a = int'(rd_addr_a);
            p.b = int'(rd_addr_b);
            if (bf_ct) begin
                t   = (w * b) % Q;
                p.e = (a + t) % Q;
                p.o = (a - t + Q) % Q;
            end else begin
                p.e = half((a + b) % Q);
                p.o = half((w * ((b - a + Q) % Q)) % Q);
            end
            pend.push_back(p);
        end
        if (wr_en) begin
            wr_count++;
            if (pend.size() == 0) begin
                e2e_err++;
            end else begin
                p = pend.pop_front();
                if (p.a != int'(wr_addr_a) || p.b != int'(wr_addr_b)) e2e_err++;
                ram[wr_addr_a] = p.e;
                ram[wr_addr_b] = p.o;
            end
        end
        if (done) begin
            done_count++;
            done_cyc = cyc;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        model();
    endtask

    task automatic check_vecs(input int run);
        foreach (vecs[i]) begin
            if (vecs[i].run == run && vecs[i].cyc == cyc) begin
                string tag;
                tag = $sformatf("run%0d cyc%0d", run, cyc);
                chk({tag, " rd_en"},     rd_en,     vecs[i].rd);
                chk({tag, " rd_addr_a"}, rd_addr_a, vecs[i].a);
                chk({tag, " rd_addr_b"}, rd_addr_b, vecs[i].b);
                chk({tag, " tw_addr"},   tw_addr,   vecs[i].tw);
                chk({tag, " wr_en"},     wr_en,     vecs[i].wr);
                chk({tag, " wr_addr_a"}, wr_addr_a, vecs[i].wa);
                chk({tag, " wr_addr_b"}, wr_addr_b, vecs[i].wb);
                chk({tag, " busy"},      busy,      vecs[i].bsy);
                chk({tag, " done"},      done,      vecs[i].dn);
                chk({tag, " bf_ct"},     bf_ct,     vecs[i].bf);
            end
        end
    endtask

    task automatic check_zero(input string name);
        chk(name, {busy, done, bf_ct, rd_en, rd_addr_a, rd_addr_b, tw_addr,
                   wr_en, wr_addr_a, wr_addr_b}, 0);
    endtask

    task automatic run_start(input logic inv_v);
        start      = 1'b1;
        inv        = inv_v;
        cyc        = 0;
        wr_count   = 0;
        done_count = 0;
        done_cyc   = -1;
        tick();
        start = 1'b0;
        inv   = 1'b0;
    endtask

    task automatic build_zetas();
        int e, z;
        for (int i = 0; i < 128; i++) begin
            e = 0;
            for (int k = 0; k < 7; k++) if (((i >> k) & 1) == 1) e |= 1 << (6 - k);
            z = 1;
            for (int n = 0; n < e; n++) z = (z * 17) % Q;
            zetas[i] = z;
        end
    endtask

    task automatic ntt_ref();
        int k, z, t;
        k = 1;
        for (int i = 0; i < 256; i++) gold[i] = orig[i];
        for (int len = 128; len >= 2; len = len / 2) begin
            for (int s = 0; s < 256; s += 2 * len) begin
                z = zetas[k];
                k++;
                for (int j = s; j < s + len; j++) begin
                    t             = (z * gold[j + len]) % Q;
                    gold[j + len] = (gold[j] - t + Q) % Q;
                    gold[j]       = (gold[j] + t) % Q;
                end
            end
        end
    endtask

    initial begin
        int nerr;

        // run 0: forward (stray start at cycle 50), run 1: inverse, run 2: reset/restart
        vecs.push_back(mk(0,   1, 1,   0, 128,   1, 0,   0,   0, 1, 0, 1));
        vecs.push_back(mk(0,   2, 1,   1, 129,   1, 0,   0,   0, 1, 0, 1));
        vecs.push_back(mk(0,   3, 1,   2, 130,   1, 0,   0,   0, 1, 0, 1));
        vecs.push_back(mk(0,   6, 1,   5, 133,   1, 1,   0, 128, 1, 0, 1));
        vecs.push_back(mk(0,  51, 1,  50, 178,   1, 1,  45, 173, 1, 0, 1));
        vecs.push_back(mk(0, 128, 1, 127, 255,   1, 1, 122, 250, 1, 0, 1));
        vecs.push_back(mk(0, 129, 0,   0,   0,   0, 1, 123, 251, 1, 0, 1));
        vecs.push_back(mk(0, 133, 0,   0,   0,   0, 1, 127, 255, 1, 0, 1));
        vecs.push_back(mk(0, 134, 1,   0,  64,   2, 0,   0,   0, 1, 0, 1));
        vecs.push_back(mk(0, 139, 1,   5,  69,   2, 1,   0,  64, 1, 0, 1));
        vecs.push_back(mk(0, 198, 1, 128, 192,   3, 1,  59, 123, 1, 0, 1));
        vecs.push_back(mk(0, 799, 1,   0,   2,  64, 0,   0,   0, 1, 0, 1));
        vecs.push_back(mk(0, 926, 1, 253, 255, 127, 1, 244, 246, 1, 0, 1));
        vecs.push_back(mk(0, 931, 0,   0,   0,   0, 1, 253, 255, 1, 0, 1));
        vecs.push_back(mk(0, 932, 0,   0,   0,   0, 0,   0,   0, 0, 1, 1));
        vecs.push_back(mk(0, 933, 0,   0,   0,   0, 0,   0,   0, 0, 0, 1));
        vecs.push_back(mk(1,   1, 1,   0,   2, 127, 0,   0,   0, 1, 0, 0));
        vecs.push_back(mk(1,   2, 1,   1,   3, 127, 0,   0,   0, 1, 0, 0));
        vecs.push_back(mk(1,   3, 1,   4,   6, 126, 0,   0,   0, 1, 0, 0));
        vecs.push_back(mk(1, 128, 1, 253, 255,  64, 1, 244, 246, 1, 0, 0));
        vecs.push_back(mk(1, 134, 1,   0,   4,  63, 0,   0,   0, 1, 0, 0));
        vecs.push_back(mk(1, 799, 1,   0, 128,   1, 0,   0,   0, 1, 0, 0));
        vecs.push_back(mk(1, 926, 1, 127, 255,   1, 1, 122, 250, 1, 0, 0));
        vecs.push_back(mk(1, 932, 0,   0,   0,   0, 0,   0,   0, 0, 1, 0));
        vecs.push_back(mk(2, 300, 1,  65,  97,   5, 1,  28,  60, 1, 0, 1));
        vecs.push_back(mk(2, 311, 1,   0, 128,   1, 0,   0,   0, 1, 0, 1));
        vecs.push_back(mk(2, 316, 1,   5, 133,   1, 1,   0, 128, 1, 0, 1));
        vecs.push_back(mk(2,1242, 0,   0,   0,   0, 0,   0,   0, 0, 1, 1));

        build_zetas();

        rst   = 1'b1;
        start = 1'b0;
        inv   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_outputs");
        rst = 1'b0;
        tick();
        check_zero("idle_outputs");

        for (int i = 0; i < 256; i++) begin
            orig[i] = int'($urandom_range(0, Q - 1));
            ram[i]  = orig[i];
        end
        ntt_ref();
        pend.delete();

        // Forward transform, with a start/inv pulse while busy
        e2e_err = 0;
        run_start(1'b0);
        while (cyc <= 940) begin
            check_vecs(0);
            if (cyc == 50) begin
                start = 1'b1;
                inv   = 1'b1;
            end
            tick();
            start = 1'b0;
            inv   = 1'b0;
        end
        chk("fwd done cycle", done_cyc, 932);
        chk("fwd done pulses", done_count, 1);
        chk("fwd wr_en pulses", wr_count, 896);
        chk("fwd write order", e2e_err, 0);
        nerr = 0;
        for (int i = 0; i < 256; i++) if (ram[i] != gold[i]) nerr++;
        chk("ntt vs reference coeff errors", nerr, 0);

        // Inverse transform on the NTT result
        e2e_err = 0;
        run_start(1'b1);
        while (cyc <= 940) begin
            check_vecs(1);
            tick();
        end
        chk("inv done cycle", done_cyc, 932);
        chk("inv wr_en pulses", wr_count, 896);
        chk("inv write order", e2e_err, 0);
        nerr = 0;
        for (int i = 0; i < 256; i++) if (ram[i] != orig[i]) nerr++;
        chk("roundtrip coeff errors", nerr, 0);

        // Reset in the middle of layer 2, then restart
        run_start(1'b0);
        while (cyc < 300) begin
            check_vecs(2);
            tick();
        end
        check_vecs(2);
        rst = 1'b1;
        #1;
        check_zero("midrun reset outputs");
        pend.delete();
        tick();
        rst        = 1'b0;
        wr_count   = 0;
        done_count = 0;
        done_cyc   = -1;
        while (cyc < 310) tick();
        chk("wr_en after reset", wr_count, 0);
        chk("done after reset", done_count, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        while (cyc <= 1250) begin
            check_vecs(2);
            tick();
        end
        chk("restart done cycle", done_cyc, 1242);
        chk("restart done pulses", done_count, 1);
        chk("restart wr_en pulses", wr_count, 896);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
